// File: rtl/speech_axil_pkg.sv
// Shared definitions for the speech AXI4-Lite register block: register
// offsets, the response code and the write/read state encodings.
package speech_axil_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_STALL,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Word index of a byte address; the low two address bits never matter.
  function automatic logic [1:0] reg_index(input logic [3:0] addr);
    return addr[3:2];
  endfunction

endpackage

// File: rtl/speech_allo_handshake.sv
// Valid/ready handoff of the allophone code to the speech core. Also tells
// the write path when a new allophone write must wait for the core.
module speech_allo_handshake (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic target_allo,
  input  logic ready,
  output logic valid,
  output logic stall
);

  logic valid_reg;

  // Set on a committed allophone write, clear once the core accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  // The code register must not change while the core has not taken it yet.
  assign stall = valid_reg && target_allo;

endmodule

// File: rtl/speech_axil_regs.sv
// AXI4-Lite slave with four read/write registers. REG1[7:0] carries an
// allophone code that is handed to the speech core with valid/ready; a new
// REG1 write is held off until the previous code has been consumed.
module speech_axil_regs
  import speech_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       ctrl_o,
  output logic [7:0]                        allo_data_o,
  output logic                              allo_valid_o,
  input  logic                              allo_ready_i,
  output logic [31:0]                       reg2_o,
  output logic [31:0]                       reg3_o
);

  localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;

  wr_state_t wr_state_reg;
  logic      aw_cap_reg;
  logic      w_cap_reg;
  logic      awready_reg;
  logic      wready_reg;
  logic      bvalid_reg;
  logic [1:0]                    wr_idx_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_reg;
  logic [BYTES-1:0]              wr_strb_reg;

  rd_state_t rd_state_reg;
  logic      arready_reg;
  logic      rvalid_reg;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] reg_bank;

  logic wr_is_allo;
  logic wr_commit;
  logic allo_load;
  logic allo_valid;
  logic allo_stall;
  logic unused_bits;

  assign wr_is_allo = (wr_idx_reg == reg_index(REG1_OFFSET));

  // A write lands either straight from IDLE, or from STALL once the core
  // has drained the previous allophone.
  assign wr_commit = ((wr_state_reg == W_IDLE) && aw_cap_reg && w_cap_reg && !allo_stall)
                  || ((wr_state_reg == W_STALL) && !allo_valid);

  assign allo_load = wr_commit && wr_is_allo && wr_strb_reg[0];

  speech_allo_handshake u_allo (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .load        (allo_load),
    .target_allo (wr_is_allo),
    .ready       (allo_ready_i),
    .valid       (allo_valid),
    .stall       (allo_stall)
  );

  // Write FSM: collect AW and W in any order, commit or stall, then respond.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_reg <= W_IDLE;
      aw_cap_reg   <= 1'b0;
      w_cap_reg    <= 1'b0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      wr_idx_reg   <= '0;
      wr_data_reg  <= '0;
      wr_strb_reg  <= '0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (aw_cap_reg && w_cap_reg) begin
            aw_cap_reg <= 1'b0;
            w_cap_reg  <= 1'b0;
            if (allo_stall) begin
              wr_state_reg <= W_STALL;
            end else begin
              wr_state_reg <= W_RESP;
              bvalid_reg   <= 1'b1;
            end
          end else begin
            if (S_AXI_AWVALID && awready_reg) begin
              aw_cap_reg  <= 1'b1;
              wr_idx_reg  <= reg_index(S_AXI_AWADDR);
              awready_reg <= 1'b0;
            end else if (!aw_cap_reg) begin
              awready_reg <= 1'b1;
            end
            if (S_AXI_WVALID && wready_reg) begin
              w_cap_reg   <= 1'b1;
              wr_data_reg <= S_AXI_WDATA;
              wr_strb_reg <= S_AXI_WSTRB;
              wready_reg  <= 1'b0;
            end else if (!w_cap_reg) begin
              wready_reg <= 1'b1;
            end
          end
        end
        W_STALL: begin
          if (!allo_valid) begin
            wr_state_reg <= W_RESP;
            bvalid_reg   <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wr_state_reg <= W_IDLE;
            bvalid_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [C_S_AXI_DATA_WIDTH-1:0] value_reg;

      // Byte-lane update of one register on a committed write.
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
          value_reg <= '0;
        end else if (wr_commit && (wr_idx_reg == 2'(gi))) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wr_strb_reg[b]) begin
              value_reg[8*b +: 8] <= wr_data_reg[8*b +: 8];
            end
          end
        end
      end

      assign reg_bank[gi] = value_reg;
    end
  endgenerate

  // Read FSM: sample the register bank on the AR handshake (pre-commit
  // values), then hold the data until the master takes it.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (S_AXI_ARVALID && arready_reg) begin
            rdata_reg    <= reg_bank[reg_index(S_AXI_ARADDR)];
            rvalid_reg   <= 1'b1;
            arready_reg  <= 1'b0;
            rd_state_reg <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_reg;
  assign S_AXI_WREADY  = wready_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = RESP_OKAY;

  assign ctrl_o       = reg_bank[0];
  assign allo_data_o  = reg_bank[1][7:0];
  assign allo_valid_o = allo_valid;
  assign reg2_o       = reg_bank[2];
  assign reg3_o       = reg_bank[3];

  // Protection bits and byte offsets carry no meaning for this block.
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_speech_axil_regs.sv
// Self-checking bench for speech_axil_regs: directed AXI4-Lite transactions
// plus a register/handoff model compared against the outputs every cycle.
module tb_speech_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] ctrl;
  logic [7:0]  allo_data;
  logic        allo_valid;
  logic        allo_ready;
  logic [31:0] reg2;
  logic [31:0] reg3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  speech_axil_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ctrl_o        (ctrl),
    .allo_data_o   (allo_data),
    .allo_valid_o  (allo_valid),
    .allo_ready_i  (allo_ready),
    .reg2_o        (reg2),
    .reg3_o        (reg3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [4];
  bit          m_allo_valid;
  bit          clr_sched;
  bit          prev_allo_valid;
  bit          prev_bvalid;
  bit          aw_seen;
  bit          w_seen;
  bit          pend;
  bit          saw_valid;
  bit          ar_next;
  logic [1:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [1:0]  pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;
  int          wlat;
  int          bv_rises = 0;
  logic [31:0] exp_q [$];

  // Model update and output comparison, once per cycle on the falling edge.
  initial begin
    logic [31:0] mask;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
        m_allo_valid = 0; clr_sched = 0; prev_allo_valid = 0; prev_bvalid = 0;
        aw_seen = 0; w_seen = 0; pend = 0; saw_valid = 0; ar_next = 0; wlat = 0;
        exp_q.delete();
      end else begin
        if (clr_sched) m_allo_valid = 0;
        clr_sched = 0;
        if (pend) wlat++;
        if (bvalid && !prev_bvalid) begin
          bv_rises++;
          if (!pend) begin
            chk("bvalid_without_write", {31'd0, bvalid}, 32'd0);
          end else begin
            if (pend_idx == 2'd1) chk("allo_commit_while_busy", {31'd0, prev_allo_valid}, 32'd0);
            if (!saw_valid) chk("write_latency", wlat, 2);
            mask = {{8{pend_strb[3]}}, {8{pend_strb[2]}}, {8{pend_strb[1]}}, {8{pend_strb[0]}}};
            m_regs[pend_idx] = (m_regs[pend_idx] & ~mask) | (pend_data & mask);
            if (pend_idx == 2'd1 && pend_strb[0]) m_allo_valid = 1;
            pend = 0;
          end
        end
        if (ar_next) chk("read_latency", {31'd0, rvalid}, 32'd1);
        ar_next = 0;
        if (rvalid) begin
          if (exp_q.size() == 0) chk("rvalid_without_read", {31'd0, rvalid}, 32'd0);
          else chk("rdata_model", rdata, exp_q[0]);
        end
        chk("ctrl_o", ctrl, m_regs[0]);
        chk("allo_data_o", {24'd0, allo_data}, {24'd0, m_regs[1][7:0]});
        chk("allo_valid_o", {31'd0, allo_valid}, {31'd0, m_allo_valid});
        chk("reg2_o", reg2, m_regs[2]);
        chk("reg3_o", reg3, m_regs[3]);
        chk("resp_okay", {28'd0, bresp, rresp}, 32'd0);
        // Handshakes visible now complete on the coming rising edge.
        if (awvalid && awready) begin aw_seen = 1; aw_idx = awaddr[3:2]; end
        if (wvalid && wready) begin w_seen = 1; w_data = wdata; w_strb = wstrb; end
        if (aw_seen && w_seen && !pend) begin
          pend = 1; pend_idx = aw_idx; pend_data = w_data; pend_strb = w_strb;
          wlat = 0; saw_valid = 0; aw_seen = 0; w_seen = 0;
        end
        if (pend && pend_idx == 2'd1 && m_allo_valid) saw_valid = 1;
        if (arvalid && arready) begin exp_q.push_back(m_regs[araddr[3:2]]); ar_next = 1; end
        if (rvalid && rready && exp_q.size() > 0) void'(exp_q.pop_front());
        clr_sched = m_allo_valid && allo_ready;
        prev_allo_valid = m_allo_valid;
        prev_bvalid = bvalid;
      end
    end
  end

  // ---------------- transaction tasks ----------------
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
    bit aw_done = 0;
    bit w_done = 0;
    bit got = 0;
    int cyc = 0;
    int bv0;
    $display("[TB] WR addr=0x%h data=0x%08h strb=%b", addr, data, strb);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(posedge clk); #1;
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      cyc++;
    end
    @(posedge clk); #1;
    awvalid = 0;
    wvalid  = 0;
    chk("wr_accept", {30'd0, aw_done, w_done}, 32'd3);
    bv0 = bv_rises;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bvalid) got = 1;
    end
    chk("bvalid_arrives", {31'd0, got}, 32'd1);
    if (!got || b_hold < 0) return;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    @(posedge clk); #1 bready = 1;
    @(posedge clk); #1 bready = 0;
    @(negedge clk);
    chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
    chk("bvalid_once", bv_rises - bv0, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int ar_dly, input int r_hold);
    bit done = 0;
    logic [31:0] first;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge clk); #1;
      arvalid = (cyc >= ar_dly);
      araddr  = addr;
      @(negedge clk);
      if (arvalid && arready) done = 1;
    end
    @(posedge clk); #1 arvalid = 0;
    chk("ar_accept", {31'd0, done}, 32'd1);
    if (!done) return;
    @(negedge clk);
    first = rdata;
    $display("[TB] RD addr=0x%h data=0x%08h", addr, first);
    chk("rvalid_next_cycle", {31'd0, rvalid}, 32'd1);
    chk("rdata_expected", first, exp);
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
      chk("rdata_hold", rdata, first);
    end
    @(posedge clk); #1 rready = 1;
    @(posedge clk); #1 rready = 0;
    @(negedge clk);
    chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; allo_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset held");
    chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valid", {29'd0, bvalid, rvalid, allo_valid}, 32'd0);
    chk("rst_regs", ctrl | reg2 | reg3 | rdata | {24'd0, allo_data}, 32'd0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", {29'd0, awready, wready, arready}, 32'd7);

    // Sequential writes and read-back of all four registers.
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 32'(i + 1), 0, 0);

    // W well ahead of AW, then AW well ahead of W.
    axi_write(4'h8, 32'h11112222, 4'hF, 3, 0, 0);
    axi_read(4'h8, 32'h11112222, 0, 0);
    axi_write(4'h8, 32'h0000BEEF, 4'hF, 0, 3, 0);
    axi_read(4'h8, 32'h0000BEEF, 0, 0);

    // Byte-lane merge; low address bits ignored on the read.
    axi_write(4'hC, 32'h12345678, 4'hF, 0, 0, 0);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(4'hE, 32'h12BB56DD, 0, 0);

    // Allophone back-pressure.
    @(posedge clk); #1 allo_ready = 0;
    axi_write(4'h4, 32'h00000041, 4'hF, 0, 0, 0);
    @(negedge clk);
    chk("allo_first_data", {24'd0, allo_data}, 32'h41);
    chk("allo_first_valid", {31'd0, allo_valid}, 32'd1);
    fork
      axi_write(4'h4, 32'h00000042, 4'hF, 0, 0, 0);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_no_bvalid", {31'd0, bvalid}, 32'd0);
        chk("stall_data_held", {24'd0, allo_data}, 32'h41);
        chk("stall_valid_held", {31'd0, allo_valid}, 32'd1);
        @(posedge clk); #1 allo_ready = 1;
        @(posedge clk); #1 allo_ready = 0;
      end
    join
    chk("allo_second_data", {24'd0, allo_data}, 32'h42);
    chk("allo_second_valid", {31'd0, allo_valid}, 32'd1);
    axi_read(4'h4, 32'h00000042, 0, 0);
    @(posedge clk); #1 allo_ready = 1;

    // Slow BREADY/RREADY and a read hitting the commit edge of a write.
    fork
      axi_write(4'h8, 32'h5A5A5A5A, 4'hF, 0, 0, 5);
      axi_read(4'h8, 32'h0000BEEF, 1, 5);
    join
    axi_read(4'h8, 32'h5A5A5A5A, 0, 0);

    // Reset while a write response is pending.
    axi_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0, -1);
    @(posedge clk); #3 rst_n = 0;
    #1;
    $display("[TB] reset asserted during write response");
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_allo_valid", {31'd0, allo_valid}, 32'd0);
    chk("rst_ctrl", ctrl, 32'h0);
    chk("rst_other_regs", reg2 | reg3 | {24'd0, allo_data}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    axi_write(4'hC, 32'h00000077, 4'hF, 0, 0, 0);
    axi_read(4'hC, 32'h00000077, 0, 0);
    axi_read(4'h0, 32'h00000000, 0, 0);
    axi_read(4'h8, 32'h00000000, 0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on run time in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/speech_axil_regs.md
SPEECH_AXIL_REGS -- requirements
Module: speech_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (four 32-bit registers).
REQ-003 SHALL have ports, one per line: name direction width meaning.
- S_AXI_ACLK in 1: sole clock, all logic on its rising edge.
- S_AXI_ARESETN in 1: reset, asynchronous, active-low.
- S_AXI_AWADDR in 4 / S_AXI_AWPROT in 3 / S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address channel; AWPROT is ignored.
- S_AXI_WDATA in 32 / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data channel.
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response channel.
- S_AXI_ARADDR in 4 / S_AXI_ARPROT in 3 / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address channel; ARPROT is ignored.
- S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data channel.
- ctrl_o out 32: contents of REG0 (CTRL).
- allo_data_o out 8: REG1[7:0], the allophone code.
- allo_valid_o out 1 / allo_ready_i in 1: allophone handoff to the speech core.
- reg2_o out 32, reg3_o out 32: contents of REG2 and REG3.

Function
REQ-004 SHALL decode the register index from AxADDR[3:2] and ignore AxADDR[1:0]: 0x0 REG0, 0x4 REG1, 0x8 REG2, 0xC REG3.
REQ-005 SHALL make all four registers read/write, with read-back equal to the last written bytes.
REQ-006 SHALL always return BRESP and RRESP = 2'b00 (OKAY).
REQ-007 SHALL use write FSM states W_IDLE, W_STALL, W_RESP.
REQ-008 In W_IDLE, SHALL assert AWREADY until an address is captured and WREADY until data is captured; the two captures may occur in either order or in the same cycle.
REQ-009 Once both AW and W are captured, SHALL commit the write on the next edge, updating each byte lane only where WSTRB is 1, and then move to W_RESP.
REQ-010 A write to REG1 while allo_valid_o=1 SHALL move to W_STALL instead and SHALL NOT commit; in W_STALL the write commits on the first cycle allo_valid_o=0, then moves to W_RESP.
REQ-011 W_RESP SHALL assert BVALID, hold it until BREADY, then return to W_IDLE.
REQ-012 AWREADY and WREADY SHALL be 0 in W_STALL and W_RESP, giving one outstanding write.
REQ-013 A committed REG1 write with WSTRB[0]=1 SHALL set allo_valid_o on the commit edge.
REQ-014 allo_valid_o SHALL clear on the edge where allo_valid_o and allo_ready_i are both 1; allo_data_o SHALL be stable while valid.
REQ-015 SHALL use read FSM states R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-016 An AR handshake SHALL register RDATA from register values before that edge's write commit, so a same-cycle write yields old data.
REQ-017 R_DATA SHALL hold RVALID and RDATA until RREADY, then return to R_IDLE.
REQ-018 SHALL give a one-cycle latency from the AR handshake to RVALID.
REQ-019 SHALL run the read and write FSMs fully independently.

Reset
REQ-020 S_AXI_ARESETN=0 SHALL asynchronously force both FSMs to IDLE, clear all registers to 0, and set every output to 0 (AWREADY, WREADY and ARREADY are asserted in the first cycle after deassertion).
REQ-021 Reset mid-transaction SHALL drop the pending AW/W captures, BVALID, RVALID and allo_valid_o without committing.

Structure
REQ-022 A shared package speech_axil_pkg SHALL hold the register offsets, the OKAY response constant and the wr_state_t and rd_state_t enums.
REQ-023 The allophone handoff SHALL be the sub-module speech_allo_handshake (valid set/clear and stall indication).

Verification
REQ-024 Sequential writes of 1,2,3,4 to 0x0..0xC, then reads of 0x0..0xC -> RDATA 1,2,3,4, all responses OKAY.
REQ-025 W asserted 3 cycles before AW (and the reverse order) -> single commit, BVALID exactly once.
REQ-026 Write 0x12345678 then write 0xAABBCCDD with WSTRB=4'b0101 -> read-back 0x12BB56DD.
REQ-027 Write 0x41 to 0x4 with allo_ready_i=0, then write 0x42 to 0x4 -> BVALID for the second write is withheld and allo_data_o stays 0x41; raising allo_ready_i for 1 cycle -> commit, allo_data_o=0x42, allo_valid_o=1.
REQ-028 BREADY/RREADY held low 5 cycles -> BVALID, RVALID and RDATA held stable; AR and write commit to the same register in one cycle -> old data returned.
REQ-029 ARESETN low during W_RESP -> BVALID=0 asynchronously, registers=0, and subsequent transactions behave normally.
